// File: rtl/pattern_streamer_v1.sv
// Wide-to-narrow pattern serialiser with start/done run control, feeding the sensor lines.
// Optional stall counter is enabled by defining PATTERN_UNDERRUN_CNT_EN.
module pattern_streamer_v1 #(
    parameter int OUT_W = 64,
    parameter int RATIO = 4,
    parameter int NCH   = 20,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_pat,
    input  logic [OUT_W*RATIO-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH-1:0]         mstream_out,
    output logic                   stream_en_o,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       pat_count
`ifdef PATTERN_UNDERRUN_CNT_EN
    ,
    output logic [CNT_W-1:0]       underrun_cnt
`endif
);

    localparam int SW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SW-1:0] LAST_SLICE = SW'(RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FIN    = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [RATIO-1:0][OUT_W-1:0] hold_q, hold_d;
    logic                        loaded_q, loaded_d;
    logic [SW-1:0]               slice_q, slice_d;
    logic [CNT_W-1:0]            num_q, num_d;
    logic [CNT_W-1:0]            pat_count_q, pat_count_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        stream_en_q, stream_en_d;
    logic [NCH-1:0]              mstream_q, mstream_d;

    logic                        out_valid_s;
    logic                        fire_s;
    logic                        last_s;
    logic [CNT_W:0]              sent_next_s;
    logic                        room_s;
    logic                        in_ready_s;
    logic                        accept_s;
    logic                        run_end_s;
    logic [OUT_W-1:0]            cur_slice_s;

    // Handshake decode; one extra count bit keeps the room compare overflow-free.
    always_comb begin
        out_valid_s = (state_q == ST_STREAM) && loaded_q;
        fire_s      = out_valid_s && out_ready;
        last_s      = (slice_q == LAST_SLICE);
        sent_next_s = {1'b0, pat_count_q} + {{CNT_W{1'b0}}, fire_s};
        room_s      = (sent_next_s < {1'b0, num_q});
        in_ready_s  = (state_q == ST_STREAM) && (!loaded_q || (fire_s && last_s)) && room_s;
        accept_s    = in_ready_s && in_valid;
        run_end_s   = fire_s && (sent_next_s == {1'b0, num_q});
        cur_slice_s = hold_q[slice_q];
    end

    // Run controller and holding-register next state.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        pat_count_d = pat_count_q;
        hold_d      = hold_q;
        loaded_d    = loaded_q;
        slice_d     = slice_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d       = num_pat;
                    pat_count_d = {CNT_W{1'b0}};
                    state_d     = (num_pat != {CNT_W{1'b0}}) ? ST_STREAM : ST_FIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (fire_s) begin
                    pat_count_d = sent_next_s[CNT_W-1:0];
                end else begin
                    pat_count_d = pat_count_q;
                end
                // A finished run drops whatever slices remain in the holding register.
                if (run_end_s) begin
                    state_d  = ST_FIN;
                    loaded_d = 1'b0;
                    slice_d  = {SW{1'b0}};
                end else if (accept_s) begin
                    hold_d   = in_data;
                    loaded_d = 1'b1;
                    slice_d  = {SW{1'b0}};
                end else if (fire_s && last_s) begin
                    loaded_d = 1'b0;
                    slice_d  = {SW{1'b0}};
                end else if (fire_s) begin
                    slice_d = slice_q + SW'(1);
                end else begin
                    slice_d = slice_q;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered status and sensor-stage values.
    always_comb begin
        done_d      = (state_d == ST_FIN);
        busy_d      = (state_d != ST_IDLE);
        stream_en_d = fire_s;
        mstream_d   = fire_s ? cur_slice_s[NCH-1:0] : {NCH{1'b0}};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= {(OUT_W*RATIO){1'b0}};
            loaded_q    <= 1'b0;
            slice_q     <= {SW{1'b0}};
            num_q       <= {CNT_W{1'b0}};
            pat_count_q <= {CNT_W{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            stream_en_q <= 1'b0;
            mstream_q   <= {NCH{1'b0}};
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            loaded_q    <= loaded_d;
            slice_q     <= slice_d;
            num_q       <= num_d;
            pat_count_q <= pat_count_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            stream_en_q <= stream_en_d;
            mstream_q   <= mstream_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign out_data    = cur_slice_s;
    assign pat_count   = pat_count_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign stream_en_o = stream_en_q;
    assign mstream_out = mstream_q;

`ifdef PATTERN_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] underrun_q, underrun_d;

    // Saturating count of streaming cycles where the sink was ready but no slice was held.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            underrun_d = {CNT_W{1'b0}};
        end else if ((state_q == ST_STREAM) && out_ready && !out_valid_s &&
                     (underrun_q != {CNT_W{1'b1}})) begin
            underrun_d = underrun_q + CNT_W'(1);
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_q <= {CNT_W{1'b0}};
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: doc/pattern_streamer_v1.md
Name: pattern_streamer_v1

Overview:
- Parametrised successor to the pattern-to-sensor streaming path.
- Accepts wide pattern words from the pattern FIFO through a valid/ready handshake.
- Serialises each wide word into RATIO narrow words, LSB slice first, and streams exactly num_pat narrow words to the sensor lines with downstream backpressure.
- Adds a start/done/busy run controller and pattern counting; sits between the pattern-input FIFO and the sensor output stage, all in one clock domain.

Parameters:
- OUT_W, 64: narrow output word width in bits.
- RATIO, 4: narrow words per input word; input width IN_W = OUT_W*RATIO; must be ≥1.
- NCH, 20: sensor lines driven, taken from out_data[NCH-1:0]; NCH ≤ OUT_W.
- CNT_W, 32: width of the pattern count and counters.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE.
- num_pat  input  CNT_W  narrow words to stream in a run; latched on an accepted start.
- in_data  input  OUT_W*RATIO  wide pattern word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  OUT_W  current narrow slice.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- mstream_out  output  NCH  registered sensor lines.
- stream_en_o  output  1  registered sensor strobe.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- pat_count  output  CNT_W  narrow words sent in the current or last run.

Behaviour:
- Reset: all outputs 0.
  - FSM returns to IDLE; holding register is emptied and its slice index cleared; counters are 0.
  - Reset during a run aborts it; no done pulse.
- FSM IDLE:
  - start=1 with num_pat≠0: latch num_pat, clear pat_count, go to STREAM.
  - start=1 with num_pat=0: go to FIN.
  - start=0: stay in IDLE.
- FSM STREAM:
  - Normal transfer:
    - Holding register has a "loaded" flag and slice index s in 0..RATIO-1.
    - out_data = hold[s*OUT_W +: OUT_W]; out_valid = loaded.
    - On fire (out_valid and out_ready): pat_count increments and s advances.
    - After slice RATIO-1: loaded clears, or reloads in the same cycle if an input word is accepted.
  - in_ready = STREAM and (not loaded, or (fire and s=RATIO-1)) and pat_count+fire < latched num_pat.
    - Back-to-back words therefore stream with no bubble.
  - Run end:
    - When a fire makes pat_count equal the latched num_pat: go to FIN.
    - Unsent slices of the current word are discarded and loaded is cleared.
    - No further input words are consumed.
  - start is ignored while busy; num_pat changes mid-run have no effect.
- FSM FIN: done=1 for exactly one cycle, then IDLE.
  - pat_count holds until the next accepted start.
- busy is 1 in STREAM and FIN.
- Sensor stage, 1 clk latency:
  - Each cycle: stream_en_o ← fire; mstream_out ← fire ? out_data[NCH-1:0] : 0.
- Arithmetic: pat_count is CNT_W wide, compared unsigned; maximum run is 2^CNT_W−1 words, and it does not wrap within a run.
- Empty input: out_valid stays 0 and the run stalls indefinitely; no timeout.
- out_ready low: out_data and s hold steady; in_ready follows the rule above.

Optional Feature:
- Macro: PATTERN_UNDERRUN_CNT_EN.
- With it defined:
  - Adds output underrun_cnt [CNT_W].
  - Counts cycles in STREAM where out_ready=1 and out_valid=0, i.e. the input starved the sensor.
  - Cleared on reset and on an accepted start; saturates at all-ones; holds after the run.
- Without it: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic run: RATIO=4, OUT_W=64, num_pat=8, two input words W0,W1 with in_valid=1, out_ready=1.
  - Expect 8 consecutive fires with slices W0[63:0],W0[127:64]…W1[255:192].
  - mstream_out/stream_en_o follow 1 cycle later.
  - done pulses once; pat_count=8; exactly 2 in_ready handshakes.
- Partial word: num_pat=6 with 2 words available.
  - Expect 6 fires; second word's slices 2,3 discarded.
  - in_ready stays 0 after the second accept; pat_count=6; FSM ends in IDLE.
- Backpressure: toggle out_ready every other cycle, num_pat=4.
  - Expect out_data stable while out_ready=0.
  - stream_en_o pulses only on the cycles after out_ready=1; 4 total.
- Zero/ignore: start with num_pat=0.
  - Expect done one cycle after start, no fires, pat_count=0.
  - A second start during a num_pat=5 run is ignored.
- Reset mid-run: assert reset after 3 of 8 words.
  - Expect all outputs 0 next cycle, no done pulse.
  - A new start with num_pat=2 streams from a fresh input word.
- Underrun, PATTERN_UNDERRUN_CNT_EN defined: num_pat=4, in_valid held low for 5 cycles after start with out_ready=1.
  - Expect underrun_cnt=5 when the run completes.
